// File: rtl/pwm_seq_pkg.sv
// Shared types and widths for the PWM pattern sequencer.
// Holds the table entry layout and the high-time computation used at every LOAD.
package pwm_seq_pkg;

    localparam int unsigned CNT_W     = 28;
    localparam int unsigned DUTY_W    = 9;
    localparam int unsigned REP_W     = 8;
    localparam int unsigned STEPS     = 4;
    localparam int unsigned IDX_W     = $clog2(STEPS);
    localparam int unsigned DUTY_FULL = 256;
    localparam int unsigned PROD_W    = CNT_W + DUTY_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } seq_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  period;
        logic [DUTY_W-1:0] duty;
        logic [REP_W-1:0]  reps;
    } entry_t;

    // High ticks per period: (period * min(duty, 256)) >> 8, truncated to counter width.
    function automatic logic [CNT_W-1:0] high_ticks(input logic [CNT_W-1:0]  period,
                                                    input logic [DUTY_W-1:0] duty);
        logic [DUTY_W-1:0] duty_c;
        logic [PROD_W-1:0] prod;
        duty_c = (duty > DUTY_W'(DUTY_FULL)) ? DUTY_W'(DUTY_FULL) : duty;
        prod   = PROD_W'(period) * PROD_W'(duty_c);
        return CNT_W'(prod >> 8);
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM counter/compare core: holds period, high time and tick count for the current step.
// led and period_end are registered and precomputed for the tick about to run.
module pwm_core
    import pwm_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             period_end,
    output logic             led
);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             end_q, end_d;
    logic             led_q, led_d;

    // enable means the next cycle is a running tick; otherwise the counter idles at 0
    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        tick_d   = '0;
        if (load) begin
            period_d = period;
            high_d   = high;
        end else if (enable && !end_q) begin
            tick_d = tick_q + CNT_W'(1);
        end
        led_d = enable && (tick_d < high_d);
        end_d = enable && (tick_d == period_d - CNT_W'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_q <= '0;
            high_q   <= '0;
            tick_q   <= '0;
            end_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            high_q   <= high_d;
            tick_q   <= tick_d;
            end_q    <= end_d;
            led_q    <= led_d;
        end
    end

    assign period_end = end_q;
    assign led        = led_q;

endmodule

// File: rtl/pwm_pattern_sequencer.sv
// Steps one PWM channel through a programmable table of period/duty/repeat entries.
// Owns the table, the IDLE/LOAD/RUN FSM, the repeat counter and the step/sequence pulses.
module pwm_pattern_sequencer
    import pwm_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              busy,
    output logic [IDX_W-1:0]  step_idx,
    output logic              cycle_done,
    output logic              seq_done,
    output logic              led
);

    seq_state_e              state_q, state_d;
    entry_t [STEPS-1:0]      table_q, table_d;
    logic [IDX_W-1:0]        step_idx_q, step_idx_d;
    logic [REP_W-1:0]        rep_q, rep_d;
    logic [REP_W-1:0]        reps_q, reps_d;
    logic                    seq_done_q, seq_done_d;
    logic                    busy_q, busy_d;

    entry_t                  cur_entry;
    logic [CNT_W-1:0]        cur_high;
    logic                    core_load;
    logic                    core_enable;
    logic                    period_end;

    // Table read happens from the registered copy, so a same-cycle write is not seen by LOAD
    assign cur_entry = table_q[step_idx_q];
    assign cur_high  = high_ticks(cur_entry.period, cur_entry.duty);

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        rep_d      = rep_q;
        reps_d     = reps_q;
        seq_done_d = 1'b0;
        table_d    = table_q;
        if (cfg_we) begin
            table_d[cfg_addr] = {cfg_period, cfg_duty, cfg_repeat};
        end
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = LOAD;
                    step_idx_d = '0;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cur_entry.period == '0) begin
                    state_d    = IDLE;
                    seq_done_d = 1'b1;
                end else begin
                    state_d = RUN;
                    rep_d   = '0;
                    reps_d  = cur_entry.reps;
                end
            end
            RUN: begin
                // stop outranks repeat, step advance and sequence completion
                if (stop) begin
                    state_d = IDLE;
                end else if (period_end) begin
                    if (rep_q < reps_q) begin
                        rep_d = rep_q + REP_W'(1);
                    end else if (step_idx_q == IDX_W'(STEPS - 1)) begin
                        if (loop) begin
                            step_idx_d = '0;
                            state_d    = LOAD;
                        end else begin
                            state_d    = IDLE;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        step_idx_d = step_idx_q + IDX_W'(1);
                        state_d    = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            table_q    <= '0;
            step_idx_q <= '0;
            rep_q      <= '0;
            reps_q     <= '0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            step_idx_q <= step_idx_d;
            rep_q      <= rep_d;
            reps_q     <= reps_d;
            seq_done_q <= seq_done_d;
            busy_q     <= busy_d;
        end
    end

    assign core_load   = (state_q == LOAD);
    assign core_enable = (state_d == RUN);

    pwm_core u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (core_load),
        .enable     (core_enable),
        .period     (cur_entry.period),
        .high       (cur_high),
        .period_end (period_end),
        .led        (led)
    );

    assign busy       = busy_q;
    assign step_idx   = step_idx_q;
    assign cycle_done = period_end;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_pwm_pattern_sequencer.sv
// Self-checking bench for pwm_pattern_sequencer against a pattern-generating reference model.
// Each started entry is expanded into its full expected output trace from the table contents.
module tb_pwm_pattern_sequencer;
    import pwm_seq_pkg::*;

    logic              clock;
    logic              reset;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [CNT_W-1:0]  cfg_period;
    logic [DUTY_W-1:0] cfg_duty;
    logic [REP_W-1:0]  cfg_repeat;
    logic              start;
    logic              stop;
    logic              loop;
    logic              busy;
    logic [IDX_W-1:0]  step_idx;
    logic              cycle_done;
    logic              seq_done;
    logic              led;

    int n_assert;
    int n_fail;

    // Reference model state; vectors are {led, busy, step_idx[1:0], cycle_done, seq_done}
    int unsigned sh_p[STEPS];
    int unsigned sh_d[STEPS];
    int unsigned sh_r[STEPS];
    logic [5:0]  exp_q[$];
    logic [5:0]  cur;
    logic [5:0]  act;
    int          m_idx;

    pwm_pattern_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .busy       (busy),
        .step_idx   (step_idx),
        .cycle_done (cycle_done),
        .seq_done   (seq_done),
        .led        (led)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic model_clear();
        for (int i = 0; i < int'(STEPS); i++) begin
            sh_p[i] = 0;
            sh_d[i] = 0;
            sh_r[i] = 0;
        end
        exp_q.delete();
        cur   = '0;
        m_idx = 0;
    endtask

    // Expand one table entry: a LOAD cycle, then (repeat+1) periods, or an end marker
    task automatic gen_entry(input int idx);
        longint      h;
        int unsigned dm;
        exp_q.push_back({1'b0, 1'b1, 2'(idx), 1'b0, 1'b0});
        if (sh_p[idx] == 0) begin
            exp_q.push_back({1'b0, 1'b0, 2'(idx), 1'b0, 1'b1});
            return;
        end
        dm = (sh_d[idx] > 256) ? 256 : sh_d[idx];
        h  = (longint'(sh_p[idx]) * longint'(dm)) / 256;
        for (int r = 0; r <= int'(sh_r[idx]); r++) begin
            for (int t = 0; t < int'(sh_p[idx]); t++) begin
                exp_q.push_back({(longint'(t) < h), 1'b1, 2'(idx),
                                 (t == int'(sh_p[idx]) - 1), 1'b0});
            end
        end
    endtask

    // Advance one clock: model consumes the inputs present at the edge, then DUT is sampled
    task automatic cycle();
        logic        c_start, c_stop, c_loop, c_we;
        int          c_addr;
        int unsigned c_p, c_d, c_r;
        c_start = start;
        c_stop  = stop;
        c_loop  = loop;
        c_we    = cfg_we;
        c_addr  = int'(cfg_addr);
        c_p     = cfg_period;
        c_d     = cfg_duty;
        c_r     = cfg_repeat;
        @(posedge clock);
        if (c_we) begin
            sh_p[c_addr] = c_p;
            sh_d[c_addr] = c_d;
            sh_r[c_addr] = c_r;
        end
        if (cur[4] && c_stop) begin
            exp_q.delete();
            cur = {1'b0, 1'b0, cur[3:2], 2'b00};
        end else if (!cur[4]) begin
            if (c_start && !c_stop) begin
                exp_q.delete();
                m_idx = 0;
                gen_entry(0);
                cur = exp_q.pop_front();
            end else begin
                cur = {1'b0, 1'b0, cur[3:2], 2'b00};
            end
        end else if (exp_q.size() == 0) begin
            if (m_idx == int'(STEPS) - 1) begin
                if (c_loop) begin
                    m_idx = 0;
                    gen_entry(0);
                    cur = exp_q.pop_front();
                end else begin
                    cur = {1'b0, 1'b0, 2'(STEPS - 1), 2'b01};
                end
            end else begin
                m_idx++;
                gen_entry(m_idx);
                cur = exp_q.pop_front();
            end
        end else begin
            cur = exp_q.pop_front();
        end
        @(negedge clock);
        act = {led, busy, step_idx, cycle_done, seq_done};
    endtask

    task automatic write_entry(input int a, input int unsigned p, input int unsigned d,
                               input int unsigned r);
        cfg_we     = 1'b1;
        cfg_addr   = IDX_W'(a);
        cfg_period = CNT_W'(p);
        cfg_duty   = DUTY_W'(d);
        cfg_repeat = REP_W'(r);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] v;
        reset = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0; cfg_duty = '0; cfg_repeat = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        model_clear();
        #2;
        v = {led, busy, step_idx, cycle_done, seq_done};
        n_assert++;
        if (v !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b want=%b", v, 6'b0);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
    endtask

    task automatic test_basic();
        int highs;
        highs = 0;
        write_entry(0, 10, 128, 1);
        write_entry(1, 0, 0, 0);
        start = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            cycle();
            start = 1'b0;
            highs += int'(led);
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL basic cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        n_assert++;
        if (highs != 10) begin
            n_fail++;
            $display("FAIL basic_led_count got=%0d want=%0d", highs, 10);
        end
    endtask

    task automatic test_duty_extremes();
        int highs;
        highs = 0;
        write_entry(0, 8, 0, 0);
        write_entry(1, 8, 300, 0);
        write_entry(2, 0, 0, 0);
        write_entry(3, 0, 0, 0);
        start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            cycle();
            start = 1'b0;
            highs += int'(led);
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL duty_extremes cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        n_assert++;
        if (highs != 8) begin
            n_fail++;
            $display("FAIL duty_led_count got=%0d want=%0d", highs, 8);
        end
    endtask

    task automatic test_loop();
        int dones;
        dones = 0;
        for (int i = 0; i < int'(STEPS); i++) write_entry(i, 4, 64, 0);
        loop  = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            cycle();
            start = 1'b0;
            if (k == 53) loop = 1'b0;
            dones += int'(seq_done);
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL loop cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        n_assert++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL loop_seq_done_count got=%0d want=%0d", dones, 1);
        end
    endtask

    task automatic test_stop();
        write_entry(0, 10, 128, 0);
        write_entry(1, 0, 0, 0);
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            start = 1'b0;
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL stop_pre cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        n_assert++;
        if ({led, busy, seq_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_abort got=%b want=%b", {led, busy, seq_done}, 3'b000);
        end
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_assert++;
        if ({busy, step_idx} !== 3'b100) begin
            n_fail++;
            $display("FAIL stop_restart got=%b want=%b", {busy, step_idx}, 3'b100);
        end
        for (int k = 1; k <= 14; k++) begin
            cycle();
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL stop_post cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
    endtask

    task automatic test_async_reset();
        int highs;
        highs = 0;
        write_entry(0, 10, 128, 0);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            start = 1'b0;
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL areset_pre cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({led, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL areset_immediate got=%b want=%b", {led, busy}, 2'b00);
        end
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            start = 1'b0;
            highs += int'(led);
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL areset_post cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        n_assert++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL areset_led_count got=%0d want=%0d", highs, 0);
        end
    endtask

    task automatic test_rewrite();
        int highs;
        highs = 0;
        write_entry(0, 8, 128, 0);
        for (int i = 1; i < int'(STEPS); i++) write_entry(i, 4, 256, 0);
        loop  = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (k == 5) begin
                cfg_we = 1'b1; cfg_addr = '0; cfg_period = CNT_W'(8);
                cfg_duty = DUTY_W'(32); cfg_repeat = '0;
            end
            cycle();
            cfg_we = 1'b0;
            start  = 1'b0;
            highs += int'(led);
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL rewrite cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        n_assert++;
        if (highs != 17) begin
            n_fail++;
            $display("FAIL rewrite_led_count got=%0d want=%0d", highs, 17);
        end
        loop = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        n_assert++;
        if (act !== cur) begin
            n_fail++;
            $display("FAIL rewrite_stop got=%b want=%b", act, cur);
        end
    endtask

    task automatic test_random();
        for (int k = 1; k <= 400; k++) begin
            cfg_we = ($urandom % 4) == 0;
            if (cfg_we) begin
                cfg_addr   = IDX_W'($urandom % STEPS);
                cfg_period = CNT_W'($urandom % 6);
                cfg_duty   = DUTY_W'($urandom % 300);
                cfg_repeat = REP_W'($urandom % 3);
            end
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 40) == 0;
            if (($urandom % 30) == 0) loop = ~loop;
            cycle();
            n_assert++;
            if (act !== cur) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", k, act, cur);
            end
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        loop   = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_duty_extremes();
        test_loop();
        test_stop();
        test_async_reset();
        test_rewrite();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
